// File: rtl/fft8_sequencer.sv
// fft8_sequencer
// Controller for an 8-point radix-2 decimation-in-time FFT that time-shares
// one external combinational butterfly. Samples are loaded in bit-reversed
// order, 3 stages x 4 butterflies run one per cycle in place, and bins are
// streamed out in natural order.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low. in_ready_o depends only on state; out_valid_o never waits for
// out_ready_i.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      input sample stream, in_real_i/in_imag_i
//   out_valid_o/out_ready_i    output bin stream, out_real_o/out_imag_o,
//                              out_index_o (bin k), out_last_o (k==7)
//   busy_o                     high while the butterflies run
//   bf_a_*/bf_b_*/bf_w_*       operands and twiddle to the butterfly
//   bf_y0_*/bf_y1_*            butterfly results, written back in place
//   dbg_state_o                FSM state for observation
module fft8_sequencer #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_real_i,
  input  logic [DATA_W-1:0]  in_imag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_real_o,
  output logic [DATA_W-1:0]  out_imag_o,
  output logic [2:0]         out_index_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic [DATA_W-1:0]  bf_a_real_o,
  output logic [DATA_W-1:0]  bf_a_imag_o,
  output logic [DATA_W-1:0]  bf_b_real_o,
  output logic [DATA_W-1:0]  bf_b_imag_o,
  output logic [COEFF_W-1:0] bf_w_real_o,
  output logic [COEFF_W-1:0] bf_w_imag_o,
  input  logic [DATA_W-1:0]  bf_y0_real_i,
  input  logic [DATA_W-1:0]  bf_y0_imag_i,
  input  logic [DATA_W-1:0]  bf_y1_real_i,
  input  logic [DATA_W-1:0]  bf_y1_imag_i,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  // Twiddles are given for 16-bit coefficients and rescaled for other widths.
  localparam int TW_SH = COEFF_W - 16;

  function automatic logic [COEFF_W-1:0] tw_scale(input int v);
    int r;
    if (TW_SH >= 0) r = v <<< TW_SH;
    else            r = v >>> (-TW_SH);
    return COEFF_W'(r);
  endfunction

  localparam logic [COEFF_W-1:0] W_POS  = tw_scale(32767);
  localparam logic [COEFF_W-1:0] W_R707 = tw_scale(23170);
  localparam logic [COEFF_W-1:0] W_N707 = tw_scale(-23170);
  localparam logic [COEFF_W-1:0] W_NEG  = tw_scale(-32768);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;   // input sample number
  logic [1:0]        j_q, j_d;       // butterfly within stage
  logic [1:0]        s_q, s_d;       // stage
  logic [2:0]        k_q, k_d;       // output bin
  logic [DATA_W-1:0] bank_re_q [8];
  logic [DATA_W-1:0] bank_im_q [8];
  logic [DATA_W-1:0] bank_re_d [8];
  logic [DATA_W-1:0] bank_im_d [8];

  logic [2:0] top, bot;
  logic [1:0] tw_idx;

  // Butterfly addressing. In LOAD/UNLOAD s=j=0, so top/bot sit on 0/1.
  always_comb begin
    top    = {j_q, 1'b0};
    bot    = {j_q, 1'b1};
    tw_idx = 2'd0;
    unique case (s_q)
      2'd1: begin
        top    = {j_q[1], 1'b0, j_q[0]};
        bot    = {j_q[1], 1'b1, j_q[0]};
        tw_idx = {j_q[0], 1'b0};
      end
      2'd2: begin
        top    = {1'b0, j_q};
        bot    = {1'b1, j_q};
        tw_idx = j_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    bf_w_real_o = W_POS;
    bf_w_imag_o = '0;
    unique case (tw_idx)
      2'd1: begin bf_w_real_o = W_R707; bf_w_imag_o = W_N707; end
      2'd2: begin bf_w_real_o = '0;     bf_w_imag_o = W_NEG;  end
      2'd3: begin bf_w_real_o = W_N707; bf_w_imag_o = W_N707; end
      default: ;
    endcase
  end

  assign bf_a_real_o = bank_re_q[top];
  assign bf_a_imag_o = bank_im_q[top];
  assign bf_b_real_o = bank_re_q[bot];
  assign bf_b_imag_o = bank_im_q[bot];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    s_d       = s_q;
    k_d       = k_q;
    bank_re_d = bank_re_q;
    bank_im_d = bank_im_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid_i) begin
          // Bit-reversed placement so the DIT stages run in natural order.
          bank_re_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_real_i;
          bank_im_d[{cnt_q[0], cnt_q[1], cnt_q[2]}] = in_imag_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        bank_re_d[top] = bf_y0_real_i;
        bank_im_d[top] = bf_y0_imag_i;
        bank_re_d[bot] = bf_y1_real_i;
        bank_im_d[bot] = bf_y1_imag_i;
        j_d = j_q + 2'd1;
        if (j_q == 2'd3) begin
          if (s_q == 2'd2) begin
            s_d     = 2'd0;
            state_d = ST_UNLOAD;
          end else begin
            s_d = s_q + 2'd1;
          end
        end
      end
      ST_UNLOAD: begin
        if (out_ready_i) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      j_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        bank_re_q[i] <= '0;
        bank_im_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      s_q       <= s_d;
      k_q       <= k_d;
      bank_re_q <= bank_re_d;
      bank_im_q <= bank_im_d;
    end
  end

  assign in_ready_o  = (state_q == ST_LOAD);
  assign busy_o      = (state_q == ST_COMPUTE);
  assign out_valid_o = (state_q == ST_UNLOAD);
  assign out_real_o  = bank_re_q[k_q];
  assign out_imag_o  = bank_im_q[k_q];
  assign out_index_o = k_q;
  assign out_last_o  = (state_q == ST_UNLOAD) && (k_q == 3'd7);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft8_sequencer.sv
// Testbench for fft8_sequencer: a combinational butterfly model closes the
// datapath loop, expected bins go to a queue when a frame is sent and are
// compared as the DUT streams them out. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_fft8_sequencer;
  localparam int DATA_W  = 16;
  localparam int COEFF_W = 16;
  localparam int EW = 2 * DATA_W + 4;

  logic clk, rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [DATA_W-1:0] in_real, in_imag, out_real, out_imag;
  logic [2:0] out_index;
  logic [1:0] dbg_state;
  logic [DATA_W-1:0] bf_a_real, bf_a_imag, bf_b_real, bf_b_imag;
  logic [COEFF_W-1:0] bf_w_real, bf_w_imag;
  logic [DATA_W-1:0] bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DATA_W-1:0] sr [8];
  logic [DATA_W-1:0] si [8];

  int tseq [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int wr_tab [4] = '{32767, 23170, 0, -23170};
  int wi_tab [4] = '{0, -23170, -32768, -23170};

  fft8_sequencer #(.DATA_W(DATA_W), .COEFF_W(COEFF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_real_i(in_real), .in_imag_i(in_imag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_real_o(out_real), .out_imag_o(out_imag),
    .out_index_o(out_index), .out_last_o(out_last), .busy_o(busy),
    .bf_a_real_o(bf_a_real), .bf_a_imag_o(bf_a_imag),
    .bf_b_real_o(bf_b_real), .bf_b_imag_o(bf_b_imag),
    .bf_w_real_o(bf_w_real), .bf_w_imag_o(bf_w_imag),
    .bf_y0_real_i(bf_y0_real), .bf_y0_imag_i(bf_y0_imag),
    .bf_y1_real_i(bf_y1_real), .bf_y1_imag_i(bf_y1_imag),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Butterfly: p = w*b >>> (COEFF_W-1), y0 = a + p, y1 = a - p, wrapping.
  logic signed [DATA_W+COEFF_W:0] pr_full, pi_full;
  logic [DATA_W-1:0] pr, pi;
  always_comb begin
    pr_full = $signed(bf_w_real) * $signed(bf_b_real) - $signed(bf_w_imag) * $signed(bf_b_imag);
    pi_full = $signed(bf_w_real) * $signed(bf_b_imag) + $signed(bf_w_imag) * $signed(bf_b_real);
    pr = DATA_W'(pr_full >>> (COEFF_W - 1));
    pi = DATA_W'(pi_full >>> (COEFF_W - 1));
    bf_y0_real = bf_a_real + pr;
    bf_y0_imag = bf_a_imag + pi;
    bf_y1_real = bf_a_real - pr;
    bf_y1_imag = bf_a_imag - pi;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_impulse(input int pos);
    for (int i = 0; i < 8; i++) begin
      sr[i] = '0;
      si[i] = '0;
    end
    sr[pos] = DATA_W'(4096);
  endtask

  // Push 8 expected bins: real part alternates even/odd value, imag zero.
  task automatic push_bins(input int re_even, input int re_odd);
    logic [2:0] k;
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      exp_q.push_back({DATA_W'((i % 2 == 0) ? re_even : re_odd), DATA_W'(0), k, (i == 7)});
    end
  endtask

  // Returns at the falling edge of the cycle in which sample 7 is accepted.
  task automatic send_frame(input bit gaps);
    int n = 0;
    int guard = 0;
    while (n < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (guard == 1) begin
        chk("load_in_ready_first", in_ready, 1);
        chk("load_out_valid_low", out_valid, 0);
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_real  = sr[n];
        in_imag  = si[n];
      end
      if (in_valid && in_ready) n++;
    end
    chk("load_count", n, 8);
  endtask

  // Walks COMPUTE up to the first out_valid cycle. With rst_at6 set, resets
  // in the 6th compute cycle and returns early.
  task automatic compute_check(input bit rst_at6);
    int cyc = 0;
    int busy_n = 0;
    bit seen = 0;
    bit aborted = 0;
    logic [31:0] wexp;
    while (!seen && !aborted && cyc < 40) begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      if (busy) begin
        busy_n++;
        chk("compute_in_ready_low", in_ready, 0);
        chk("compute_out_valid_low", out_valid, 0);
        if (busy_n <= 12) begin
          wexp = {COEFF_W'(wr_tab[tseq[busy_n-1]]), COEFF_W'(wi_tab[tseq[busy_n-1]])};
          chk("twiddle_schedule", {bf_w_real, bf_w_imag}, wexp);
        end
        if (rst_at6 && busy_n == 6) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_in_ready", in_ready, 1);
          chk("rst_mid_busy", busy, 0);
          chk("rst_mid_out_valid", out_valid, 0);
          chk("rst_mid_bank_clear", {bf_a_real, bf_b_real}, 0);
          aborted = 1;
        end
      end
      if (out_valid) seen = 1;
    end
    if (!aborted) begin
      chk("latency_to_out_valid", cyc, 13);
      chk("busy_cycles", busy_n, 12);
    end
  endtask

  // Starts in the first out_valid cycle; ends in the out_last cycle.
  task automatic recv_frame(input bit stress);
    int got = 0;
    int guard = 0;
    int stall_left = 0;
    bit stalled = 0;
    logic [EW-1:0] cur, prev, exp;
    prev = '0;
    while (got < 8 && guard < 300) begin
      guard++;
      if (stress && stall_left == 0 && $urandom_range(0, 3) == 0)
        stall_left = $urandom_range(1, 5);
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (out_valid) begin
        chk("unload_in_ready_low", in_ready, 0);
        cur = {out_real, out_imag, out_index, out_last};
        if (stalled) chk("unload_stable", cur, prev);
        if (out_ready) begin
          chk("exp_available", (exp_q.size() > 0), 1);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          chk("bin", cur, exp);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev = cur;
        end
      end
      if (got < 8) @(negedge clk);
    end
    chk("unload_count", got, 8);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_state", dbg_state, 0);
    chk("reset_bf_ops", {bf_a_real, bf_a_imag, bf_b_real, bf_b_imag}, 0);
    rst_n = 1'b1;

    // Impulse at n=0 -> flat spectrum.
    set_impulse(0);
    push_bins(4096, 4096);
    send_frame(0);
    compute_check(0);
    recv_frame(0);

    // Impulse at n=4 -> alternating spectrum, truncated by the twiddle.
    set_impulse(4);
    push_bins(4095, -4095);
    send_frame(0);
    compute_check(0);
    recv_frame(0);

    // Handshake stress on both sides.
    set_impulse(0);
    push_bins(4096, 4096);
    send_frame(1);
    compute_check(0);
    recv_frame(1);

    // Reset in the middle of COMPUTE, then a clean frame.
    set_impulse(4);
    send_frame(0);
    compute_check(1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_impulse(0);
    push_bins(4096, 4096);
    send_frame(0);
    compute_check(0);
    recv_frame(0);

    // Back-to-back frames with the downstream always ready.
    set_impulse(0);
    push_bins(4096, 4096);
    send_frame(0);
    compute_check(0);
    recv_frame(0);
    set_impulse(4);
    push_bins(4095, -4095);
    send_frame(0);
    compute_check(0);
    recv_frame(0);

    @(negedge clk);
    chk("end_in_ready", in_ready, 1);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft8_sequencer.md
Name: fft8_sequencer

Overview:
- Controller for an 8-point radix-2 decimation-in-time FFT built around the existing single combinational butterfly datapath.
- Accepts 8 complex samples over a valid/ready stream and stores them in bit-reversed order in an internal 8-entry register bank.
- Runs 3 stages × 4 butterflies through one external butterfly, one butterfly per cycle, writing results back in place.
- Streams the 8 bins out in natural order. Sits between the framing/windowing front end and the vowel feature extractor.

Parameters:
- DATA_W, 16, sample/bin component width, two's complement Q1.(DATA_W-1); must match butterfly in/out width.
- COEFF_W, 16, twiddle component width, Q1.(COEFF_W-1); must match butterfly coefficient width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high while accepting samples.
- in_real, in_imag  in  DATA_W each  input sample.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts bin.
- out_real, out_imag  out  DATA_W each  output bin.
- out_index  out  3  bin number k.
- out_last  out  1  high with k=7.
- busy  out  1  high in COMPUTE.
- bf_a_real, bf_a_imag, bf_b_real, bf_b_imag  out  DATA_W each  butterfly operands (top, bottom).
- bf_w_real, bf_w_imag  out  COEFF_W each  twiddle to butterfly.
- bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag  in  DATA_W each  butterfly results.

Behaviour:
- FSM states: LOAD, COMPUTE, UNLOAD.
- Reset (async, rst_n=0):
  - state=LOAD; all counters 0; register bank cleared to 0.
  - in_ready=1; out_valid=0; busy=0; out_last=0.
  - bf_* outputs reflect entry 0/1 (all zero).
- LOAD:
  - in_ready=1. On in_valid&in_ready, sample n (counter 0..7) is written to bank[bitrev3(n)].
  - After the 8th accept → COMPUTE on the next cycle; in_ready drops the same edge.
  - Gaps in in_valid simply stall the counter.
- COMPUTE: exactly 12 cycles, busy=1, in_ready=0, out_valid=0.
  - Stage s=0..2, butterfly j=0..3, j increments every cycle, s increments on j wrap.
  - span = 1<<s; pos = j & (span-1); top = ((j>>s)<<(s+1)) + pos; bot = top + span.
  - bf_a = bank[top], bf_b = bank[bot] (combinational from registers).
  - Twiddle index t = pos<<(2-s); bf_w from a 4-entry ROM:
    - t0 = (32767, 0)
    - t1 = (23170, -23170)
    - t2 = (0, -32768)
    - t3 = (-23170, -23170)
    - Values shown for COEFF_W=16; scale by 2^(COEFF_W-16) otherwise.
  - At each rising edge: bank[top] ← bf_y0, bank[bot] ← bf_y1.
  - After s=2, j=3 → UNLOAD.
  - Total latency from 8th input accept to first out_valid: 13 cycles.
- UNLOAD:
  - out_valid=1; out_real/imag = bank[k]; out_index=k; out_last=(k==7).
  - k advances only on out_valid&out_ready. Outputs hold stable while out_ready=0.
  - On the 8th transfer → LOAD, with in_ready=1 on the next cycle.
  - No overlap: inputs are never accepted outside LOAD.
- Arithmetic:
  - The controller performs no arithmetic on data; scaling, truncation and wrap are the butterfly's.
  - There is no saturation. Callers keep |x| ≤ full-scale/8 to avoid wrap.
- Reset mid-operation: any state returns to LOAD immediately; the partial frame is discarded and the bank is cleared.
- bf_* outputs during LOAD/UNLOAD are don't-care for the datapath, but must be driven with no X.

Test Plan:
- Impulse: x[0]=(4096,0), x[1..7]=0 → all 8 bins (4096,0); out_index 0..7; out_last only on k=7; first out_valid 13 cycles after 8th accept.
- Alternating: x[4]=(4096,0), others 0 → bins k even (4095,0), k odd (-4095,0), reflecting truncation of 4096*32767>>>15.
- Schedule check: during COMPUTE, (top,bot,t) sequence:
  - s0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - s1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - s2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - busy high exactly 12 cycles.
- Handshake stress: random in_valid gaps and random out_ready low periods (up to 5 cycles):
  - results identical to the impulse case; outputs stable while stalled.
  - in_ready=0 throughout COMPUTE/UNLOAD.
- Reset mid-COMPUTE: assert rst_n=0 at compute cycle 6 → in_ready=1, busy=0, out_valid=0 immediately; the following full impulse frame gives the correct result.
- Back-to-back frames: impulse then alternating frame with out_ready=1 constant → second frame loads starting the cycle after out_last, and its bins match expected.
